imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream boot loader that writes a program image into the instruction RAM, which the CPU core fetches as 32-bit words via its 14-bit word address.
- Holds the core in reset while loading and releases it once a checksum-verified image is in place.
- Sits between a host byte source (UART receiver or bench driver) and the write port of the instruction RAM.

Parameters:
- ADDR_W, 14, instruction RAM word-address width; depth is 2^ADDR_W.
- BASE_ADDR, 0, word address of the first loaded word.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse: begin a load
- byte_valid  in  1  source has a byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction RAM write strobe
- waddr  out  ADDR_W  instruction RAM word address
- wdata  out  32  instruction RAM write word
- cpu_rst_n  out  1  reset to the CPU core, active-low
- busy  out  1  load in progress
- done  out  1  last load succeeded
- err  out  1  last load failed

Behaviour:
- Stream format:
  - Header: word count N, 16-bit little-endian, low byte first.
  - Payload: N words, each 4 bytes little-endian.
  - Trailer: 1 checksum byte equal to the sum of all payload bytes mod 256. Header bytes are excluded from the sum.
- Handshake:
  - A byte is accepted only when byte_valid && byte_ready.
  - byte_ready = 1 only in HDR_LO, HDR_HI, DATA and CSUM.
  - byte_ready is registered and combinationally independent of byte_valid.
- States and transitions:
  - IDLE: wait for start.
  - HDR_LO, HDR_HI: capture N.
  - DATA: collect payload bytes.
  - CSUM: compare the checksum byte.
  - DONE and ERR: terminal until the next start.
  - IDLE/DONE/ERR --start--> HDR_LO. This clears the byte index, word index, checksum accumulator, done and err.
  - HDR_LO --accept--> HDR_HI.
  - HDR_HI --accept--> DATA if 1 <= N <= 2^ADDR_W; otherwise --> ERR.
  - DATA: after the accept that completes word N --> CSUM.
  - CSUM --accept--> DONE on checksum match; otherwise --> ERR.
- Write timing:
  - The cycle after the 4th byte of a word is accepted: we=1 for exactly one cycle, waddr = (BASE_ADDR + word index) mod 2^ADDR_W, wdata = the assembled word.
  - Byte 0 of the word occupies wdata[7:0].
  - Back-to-back accepts are allowed every cycle; writes never stall the stream.
- Outputs:
  - busy = 1 in HDR_LO..CSUM.
  - done = 1 in DONE; err = 1 in ERR.
  - cpu_rst_n = 1 only in DONE. It goes low in the cycle after start is accepted and stays low through loading and in ERR.
- Reset values (and on rst_n low mid-load):
  - State IDLE.
  - byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_rst_n=0.
  - A partial word is discarded and no write is issued.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as an accept: accept processed, start ignored.
  - Gaps in byte_valid: state held, no spurious writes.
  - Address wrap past 2^ADDR_W-1 to 0 is legal with a nonzero BASE_ADDR.
  - The checksum accumulator is 8 bits and wraps.
  - Words already written before an error are not rolled back.

Decomposition:
- Shared package `loader_pkg`:
  - State enum: IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR.
  - Header width constant: 16.
  - Checksum width constant: 8.
- No sub-module needed: a single FSM plus byte, word and checksum counters.

Test Plan:
- Nominal load, BASE_ADDR=0:
  - Stimulus: start, then bytes 02 00 93 00 50 00 13 81 10 00 87, one per cycle.
  - Response: write (0, 0x00500093), then write (1, 0x00108113); done=1; cpu_rst_n rises.
  - Core run: x1=5, x2=6 at core writeback.
- Bad checksum:
  - Stimulus: same stream with trailer 0x86.
  - Response: both writes occur; err=1, done=0, cpu_rst_n stays 0.
- Illegal header:
  - Stimulus: header 00 00 (N=0).
  - Response: ERR after the 2nd byte, no writes, byte_ready=0.
  - Stimulus: N=0x4001 with ADDR_W=14.
  - Response: ERR after the 2nd byte.
- Backpressure:
  - Stimulus: nominal stream with byte_valid toggling 1-0-0-1 randomly.
  - Response: identical writes and done; exactly 2 write pulses.
- Wrap:
  - Stimulus: BASE_ADDR=0x3FFF, N=2.
  - Response: write addresses 0x3FFF, then 0x0000.
- Reset and restart:
  - Stimulus: rst_n low after 6 payload bytes.
  - Response: outputs at reset values, no write for the partial word.
  - Stimulus: start during busy.
  - Response: ignored.
  - Stimulus: start after DONE.
  - Response: cpu_rst_n drops the next cycle, done clears.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction RAM boot loader
package loader_pkg;

    // Stream framing widths: 16-bit little-endian word count, 8-bit additive checksum.
    localparam int HDR_W  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills the instruction RAM and gates CPU reset
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle pulse that begins a load (ignored while busy)
//   byte_valid/byte_data  host byte stream; byte_ready is the registered accept
//   we/waddr/wdata        instruction RAM write port, one pulse per assembled word
//   cpu_rst_n             core reset, released only after a checksum-verified image
//   busy/done/err         load status
module imem_loader
    import loader_pkg::*;
#(
    parameter int              ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    loader_state_t     state, state_d;
    logic [HDR_W-1:0]  n_words;
    logic [HDR_W-1:0]  word_idx;
    logic [1:0]        byte_idx;
    logic [CSUM_W-1:0] csum;
    logic [23:0]       word_buf;

    logic              accept;
    logic              start_taken;
    logic [HDR_W-1:0]  hdr_n;
    logic              hdr_ok;
    logic              last_word;

    assign accept      = byte_valid && byte_ready;
    assign start_taken = start && (state == IDLE || state == DONE || state == ERR);
    // The full count is only known as the high header byte is accepted.
    assign hdr_n       = {byte_data, n_words[7:0]};
    assign hdr_ok      = (hdr_n != '0) && ({16'd0, hdr_n} <= MAX_WORDS);
    assign last_word   = (word_idx + 16'd1) == n_words;

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_d = HDR_LO;
            HDR_LO:          if (accept) state_d = HDR_HI;
            HDR_HI:          if (accept) state_d = hdr_ok ? DATA : ERR;
            DATA:            if (accept && byte_idx == 2'd3 && last_word) state_d = CSUM;
            CSUM:            if (accept) state_d = (csum == byte_data) ? DONE : ERR;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            word_buf   <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state <= state_d;
            we    <= 1'b0;

            // Status flags come from the next state so they are flop outputs
            // that never depend combinationally on byte_valid.
            byte_ready <= (state_d == HDR_LO) || (state_d == HDR_HI) ||
                          (state_d == DATA)   || (state_d == CSUM);
            busy       <= (state_d == HDR_LO) || (state_d == HDR_HI) ||
                          (state_d == DATA)   || (state_d == CSUM);
            done       <= (state_d == DONE);
            err        <= (state_d == ERR);
            cpu_rst_n  <= (state_d == DONE);

            if (start_taken) begin
                word_idx <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end

            if (accept) begin
                case (state)
                    HDR_LO: n_words[7:0]  <= byte_data;
                    HDR_HI: n_words[15:8] <= byte_data;
                    DATA: begin
                        csum     <= csum + byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                // Word complete: write goes out next cycle while
                                // the stream keeps flowing.
                                we       <= 1'b1;
                                waddr    <= BASE_ADDR + word_idx[ADDR_W-1:0];
                                wdata    <= {byte_data, word_buf};
                                word_idx <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready0, we0, cpu_rst_n0, busy0, done0, err0;
    logic [13:0] waddr0;
    logic [31:0] wdata0;
    logic        byte_ready1, we1, cpu_rst_n1, busy1, done1, err1;
    logic [13:0] waddr1;
    logic [31:0] wdata1;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(14), .BASE_ADDR(14'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready0), .we(we0), .waddr(waddr0),
        .wdata(wdata0), .cpu_rst_n(cpu_rst_n0), .busy(busy0), .done(done0), .err(err0)
    );

    imem_loader #(.ADDR_W(14), .BASE_ADDR(14'h3FFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready1), .we(we1), .waddr(waddr1),
        .wdata(wdata1), .cpu_rst_n(cpu_rst_n1), .busy(busy1), .done(done1), .err(err1)
    );

    int errors = 0;
    int checks = 0;
    logic [45:0] wq0[$];
    logic [45:0] wq1[$];

    always @(negedge clk) begin
        if (we0 === 1'b1) wq0.push_back({waddr0, wdata0});
        if (we1 === 1'b1) wq1.push_back({waddr1, wdata1});
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq0.delete();
        wq1.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit with_start);
        int  tmo;
        logic rdy;
        byte_valid = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = with_start;
        tmo = 0;
        rdy = 1'b0;
        while (!rdy && tmo < 50) begin
            rdy = byte_ready0;
            @(negedge clk);
            start = 1'b0;
            tmo++;
        end
        if (!rdy) check("byte_accept_timeout", 0, 1);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] bq[$], input int gap_max);
        foreach (bq[i]) send_byte(bq[i], gap_max, 1'b0);
    endtask

    // Reference: one write per payload word, addresses BASE+i mod 2^14.
    task automatic check_writes(input logic [31:0] ws[$]);
        check("write_count", 64'(wq0.size()), 64'(ws.size()));
        check("write_count_wrap", 64'(wq1.size()), 64'(ws.size()));
        for (int i = 0; i < ws.size(); i++) begin
            if (i < wq0.size()) check("write_base0", wq0[i], {14'(i), ws[i]});
            if (i < wq1.size()) check("write_wrap", wq1[i], {14'((16383 + i) % 16384), ws[i]});
        end
    endtask

    function automatic logic [7:0] sum_bytes(input logic [31:0] ws[$]);
        int s = 0;
        foreach (ws[i]) s += ws[i][7:0] + ws[i][15:8] + ws[i][23:16] + ws[i][31:24];
        return 8'(s % 256);
    endfunction

    task automatic build(input logic [15:0] n, input logic [31:0] ws[$], input logic [7:0] trailer,
                         input bit hdr_only, output logic [7:0] bq[$]);
        bq = {};
        bq.push_back(n[7:0]);
        bq.push_back(n[15:8]);
        if (!hdr_only) begin
            foreach (ws[i]) for (int k = 0; k < 4; k++) bq.push_back(ws[i][8*k +: 8]);
            bq.push_back(trailer);
        end
    endtask

    task automatic check_end(input bit exp_done, input bit exp_err);
        repeat (2) @(negedge clk);
        check("done", done0, exp_done);
        check("err", err0, exp_err);
        check("cpu_rst_n", cpu_rst_n0, exp_done);
        check("busy_end", busy0, 0);
        check("byte_ready_end", byte_ready0, 0);
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        logic [7:0]  trailer;
        bit          hdr_only;
        int          gap;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  bq[$];
        logic [31:0] ws[$];
        logic [7:0]  cs;
        bit          bad;
        int          n;

        vecs[0] = '{16'd2,      32'h00500093, 32'h00108113, 2, 8'h87, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{16'd2,      32'h00500093, 32'h00108113, 2, 8'h86, 1'b0, 0, 1'b0, 1'b1};
        vecs[2] = '{16'd0,      32'h0,        32'h0,        0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
        vecs[3] = '{16'h4001,   32'h0,        32'h0,        0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
        vecs[4] = '{16'd1,      32'hDEADBEEF, 32'h0,        1, 8'h38, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{16'd2,      32'h00500093, 32'h00108113, 2, 8'h87, 1'b0, 3, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        do_reset();
        check("reset_outputs", {byte_ready0, we0, waddr0, wdata0, busy0, done0, err0, cpu_rst_n0}, '0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            pulse_start();
            check("busy_after_start", busy0, 1);
            check("cpu_rst_after_start", cpu_rst_n0, 0);
            ws = {};
            if (vecs[v].nw > 0) ws.push_back(vecs[v].w0);
            if (vecs[v].nw > 1) ws.push_back(vecs[v].w1);
            build(vecs[v].n, ws, vecs[v].trailer, vecs[v].hdr_only, bq);
            send_stream(bq, vecs[v].gap);
            if (vecs[v].hdr_only) check("err_after_hdr", err0, 1);
            check_end(vecs[v].exp_done, vecs[v].exp_err);
            check_writes(ws);
        end

        // Start after DONE: core goes back into reset the next cycle.
        pulse_start();
        check("restart_cpu_rst_n", cpu_rst_n0, 0);
        check("restart_done", done0, 0);
        check("restart_busy", busy0, 1);

        // Reset after six payload bytes: one full word written, partial word dropped.
        do_reset();
        pulse_start();
        ws = {32'h00500093, 32'h00108113};
        build(16'd2, ws, 8'h87, 1'b0, bq);
        for (int i = 0; i < 8; i++) send_byte(bq[i], 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midload_reset_outputs",
              {byte_ready0, we0, waddr0, wdata0, busy0, done0, err0, cpu_rst_n0}, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midload_write_count", 64'(wq0.size()), 1);
        check("midload_idle", busy0, 0);

        // Start during busy, including one coincident with a byte accept.
        do_reset();
        pulse_start();
        send_byte(bq[0], 0, 1'b0);
        send_byte(bq[1], 0, 1'b0);
        pulse_start();
        send_byte(bq[2], 0, 1'b1);
        for (int i = 3; i < bq.size(); i++) send_byte(bq[i], 0, 1'b0);
        check_end(1'b1, 1'b0);
        check_writes(ws);

        // Randomized images with random gaps and occasional bad checksums.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            n = $urandom_range(4, 1);
            ws = {};
            for (int i = 0; i < n; i++) ws.push_back($urandom);
            bad = ($urandom_range(3, 0) == 0);
            cs = sum_bytes(ws);
            if (bad) cs = cs + 8'd1;
            build(16'(n), ws, cs, 1'b0, bq);
            pulse_start();
            send_stream(bq, 3);
            check_end(!bad, bad);
            check_writes(ws);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
